order_match_engine: RTL and testbench
=====================================

// Module: order_match_engine
// PURPOSE
//  Command initiator for the bid and ask heap managers. Accepts one incoming limit order and crosses it
//  against the opposite heap's root. Each full fill issues POP, a partial fill of the resting order issues UPDATE.
//  Any unfilled remainder is PUSHed to the order's own side. Each fill emits one trade record.
//  Sits between order ingress and the two heap instances (bid = max-heap, ask = min-heap).
// PARAMETERS
//  MAX_FILLS   1023  fills allowed per order before the remainder is forced to rest (livelock guard)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  order_valid  in   1   incoming order present
//  order_ready  out  1   engine accepts order this cycle
//  order_side   in   1   0=buy, 1=sell
//  order_data   in   32  `PRICE=[31:16], `QTY=[15:0]
//  order_done   out  1   1-cycle pulse: order fully processed
//  reject       out  1   1-cycle pulse with order_done: remainder could not rest (own heap full)
//  trade_valid  out  1   1-cycle pulse per fill
//  trade_side   out  1   aggressor side
//  trade_price  out  16  resting order's price
//  trade_qty    out  16  filled quantity
//  bid_cmd      out  2   command to bid heap
//  bid_data     out  32  data to bid heap
//  bid_root / bid_empty / bid_full / bid_busy / bid_done   in  32/1/1/1/1   bid heap status
//  ask_cmd      out  2   command to ask heap
//  ask_data     out  32  data to ask heap
//  ask_root / ask_empty / ask_full / ask_busy / ask_done   in  32/1/1/1/1   ask heap status
// BEHAVIOUR
//  Reset: all outputs 0 (order_ready=0; cmds=`CMD_NOP). rst does not reset the heaps.
//  Reset mid-order: the order is abandoned, with no order_done.
//  Handshake: the order is taken on order_valid && order_ready. order_ready=1 only in IDLE with !bid_busy && !ask_busy.
//   This covers the heaps' post-reset BRAM clear. The engine latches side, price, rem_qty=`QTY and fills=0.
//  Heap cmd rule: cmd held for exactly 1 cycle, then `CMD_NOP. Data is valid in the same cycle.
//   The engine then waits for the heap's done pulse. It ignores that heap's root, empty and full until one SETTLE cycle after done.
//  Opp heap = ask for a buy, bid for a sell. Own heap = the other one.
//  FSM: IDLE -> EVAL -> {ISSUE_POP | ISSUE_UPD | ISSUE_PUSH | FINISH}
//   ISSUE_POP and ISSUE_UPD -> WAIT_DONE -> SETTLE -> EVAL. ISSUE_PUSH -> WAIT_DONE -> SETTLE -> FINISH.
//  EVAL:
//   - rem_qty==0 -> FINISH.
//   - Crossed when the opp heap is !empty and the price crosses (buy: ask_price<=price; sell: bid_price>=price),
//     and fills<MAX_FILLS. Root qty = rq. If crossed:
//       - rem_qty>=rq: ISSUE_POP. Emit trade(rq, root price). rem_qty-=rq.
//       - rem_qty<rq: ISSUE_UPD with {root price, rq-rem_qty}. Emit trade(rem_qty). rem_qty=0.
//       - fills+=1 in both cases.
//   - Not crossed and own heap !full: ISSUE_PUSH {price, rem_qty}. rem_qty=0.
//   - Not crossed and own heap full: FINISH with reject=1.
//  trade_valid pulses in the ISSUE cycle. trade_* fields are held until the next trade.
//  FINISH: order_done=1 for 1 cycle -> IDLE. Minimum latency from accept to order_done is 1+1+1+heap+1+1 cycles.
//  Equal prices cross. A 16-bit unsigned price compare. qty math is unsigned 16-bit and cannot underflow by construction.
//  An order with QTY=0 -> order_done next EVAL, with no heap commands and no trade.
//  Never issue commands to both heaps in the same cycle. Never issue to a heap while it is busy.
// STRUCTURE
//  order_defines.v (shared): `PRICE/`QTY field macros, `CMD_NOP=2'b00, `CMD_PUSH=2'b01, `CMD_POP=2'b10,
//   `CMD_UPDATE=2'b11, `TYPE_BID/`TYPE_ASK, FSM state localparams kept local.
//  One sub-module: heap_port_driver, instantiated per heap.
//   It handles the 1-cycle cmd pulse, waits for done, generates SETTLE, and reports idle.
//  Cross/fill arithmetic stays in the top.
// TESTING (two real heap_manager instances + BRAM models)
//  1. After rst, order_ready stays 0 until both heap busy flags fall (>=1024 cycles).
//     Then buy {100,10} on an empty book -> PUSH to bid; bid_root=={100,10}; order_done, no trade.
//  2. Ask {101,5} resting, buy {101,5} -> POP ask; trade(101,5); ask_empty=1; nothing pushed.
//  3. Ask {101,8} resting, buy {102,3} -> UPDATE ask with {101,5}; trade(101,3); ask_root=={101,5}.
//  4. Asks {100,2},{101,2},{103,9}; buy {101,10} -> trades (100,2),(101,2).
//     Bid {101,6} pushed; ask_root=={103,9}.
//  5. Bid heap full (1023 entries), no asks, buy {50,1} -> reject and order_done together; bid count unchanged.
//  6. Assert rst mid-WAIT_DONE -> no order_done, cmds NOP next cycle.
//     A new order is accepted once the heaps are idle. Also check QTY=0 -> order_done, zero heap commands.

Source files
------------

// File: rtl/order_match_engine_pkg.sv
// Shared types for the order matching engine: heap command encoding, order
// word layout, side encoding and the price-cross test.
package order_match_engine_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_PUSH   = 2'b01,
    CMD_POP    = 2'b10,
    CMD_UPDATE = 2'b11
  } heap_cmd_e;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  // Heap entries and incoming orders share this layout.
  typedef struct packed {
    logic [15:0] price;
    logic [15:0] qty;
  } order_t;

  // Equal prices cross; a buy takes asks at or below its limit, a sell
  // takes bids at or above it.
  function automatic logic crosses(input logic side, input logic [15:0] limit,
                                   input logic [15:0] root_price);
    return (side == SIDE_BUY) ? (root_price <= limit) : (root_price >= limit);
  endfunction

endpackage

// File: rtl/heap_port_driver.sv
// Per-heap command port: issues a one-cycle command, waits for the heap's done
// pulse, then spends one settle cycle before reporting idle again.
module heap_port_driver
  import order_match_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  heap_cmd_e   cmd_in,
  input  logic [31:0] data_in,
  input  logic        heap_done,
  output logic [1:0]  cmd,
  output logic [31:0] data,
  output logic        complete,
  output logic        idle
);

  typedef enum logic [1:0] {D_IDLE, D_CMD, D_WAIT, D_SETTLE} drv_state_e;

  drv_state_e state, nxt;
  heap_cmd_e  cmd_q;
  logic [31:0] data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= D_IDLE;
      cmd_q  <= CMD_NOP;
      data_q <= '0;
    end else begin
      state <= nxt;
      cmd_q <= CMD_NOP;
      if (state == D_IDLE && start) begin
        cmd_q  <= cmd_in;
        data_q <= data_in;
      end
    end
  end

  // NOTE: nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt = state;
    unique case (state)
      D_IDLE:   if (start) nxt = D_CMD;
      D_CMD:    nxt = D_WAIT;
      D_WAIT:   if (heap_done) nxt = D_SETTLE;
      D_SETTLE: nxt = D_IDLE;
      default:  nxt = D_IDLE;
    endcase
  end

  assign cmd      = cmd_q;
  assign data     = data_q;
  assign complete = (state == D_WAIT) && heap_done;
  assign idle     = (state == D_IDLE);

endmodule

// File: rtl/order_match_engine.sv
// Crosses one incoming limit order against the opposite heap root, issuing
// POP/UPDATE per fill and PUSHing any remainder onto the order's own heap.
module order_match_engine
  import order_match_engine_pkg::*;
#(
  parameter int MAX_FILLS = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        order_valid,
  output logic        order_ready,
  input  logic        order_side,
  input  logic [31:0] order_data,
  output logic        order_done,
  output logic        reject,
  output logic        trade_valid,
  output logic        trade_side,
  output logic [15:0] trade_price,
  output logic [15:0] trade_qty,
  output logic [1:0]  bid_cmd,
  output logic [31:0] bid_data,
  input  logic [31:0] bid_root,
  input  logic        bid_empty,
  input  logic        bid_full,
  input  logic        bid_busy,
  input  logic        bid_done,
  output logic [1:0]  ask_cmd,
  output logic [31:0] ask_data,
  input  logic [31:0] ask_root,
  input  logic        ask_empty,
  input  logic        ask_full,
  input  logic        ask_busy,
  input  logic        ask_done
);

  localparam int FILL_W = $clog2(MAX_FILLS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_ISSUE_POP, S_ISSUE_UPD, S_ISSUE_PUSH, S_WAIT_DONE, S_SETTLE, S_FINISH
  } state_e;

  state_e            state, nxt;
  logic              side_q, ready_q, reject_q, rested_q;
  logic [15:0]       price_q, rem_q;
  logic [FILL_W-1:0] fills_q;
  logic              trade_valid_q, trade_side_q;
  logic [15:0]       trade_price_q, trade_qty_q;

  order_t    in_ord, opp_ord;
  logic      opp_empty, own_full, crossed, accept;
  logic      do_fill, do_push, do_reject, opp_start, own_start;
  logic      bid_start, ask_start, bid_complete, ask_complete, bid_idle, ask_idle;
  logic [15:0] fill_qty;
  heap_cmd_e   drv_cmd;
  logic [31:0] drv_data;

  assign in_ord    = order_data;
  assign opp_ord   = (side_q == SIDE_BUY) ? ask_root  : bid_root;
  assign opp_empty = (side_q == SIDE_BUY) ? ask_empty : bid_empty;
  assign own_full  = (side_q == SIDE_BUY) ? bid_full  : ask_full;
  assign accept    = order_valid && order_ready;
  assign crossed   = !opp_empty && crosses(side_q, price_q, opp_ord.price)
                     && (fills_q < FILL_W'(MAX_FILLS));
  assign fill_qty  = (rem_q >= opp_ord.qty) ? opp_ord.qty : rem_q;

  always_comb begin
    nxt       = state;
    do_fill   = 1'b0;
    do_push   = 1'b0;
    do_reject = 1'b0;
    opp_start = 1'b0;
    own_start = 1'b0;
    drv_cmd   = CMD_NOP;
    drv_data  = '0;
    unique case (state)
      S_IDLE: if (accept) nxt = S_EVAL;
      S_EVAL: begin
        if (rem_q == '0) begin
          nxt = S_FINISH;
        end else if (crossed) begin
          do_fill   = 1'b1;
          opp_start = 1'b1;
          if (rem_q >= opp_ord.qty) begin
            nxt      = S_ISSUE_POP;
            drv_cmd  = CMD_POP;
            drv_data = opp_ord;
          end else begin
            nxt      = S_ISSUE_UPD;
            drv_cmd  = CMD_UPDATE;
            drv_data = {opp_ord.price, opp_ord.qty - rem_q};
          end
        end else if (!own_full) begin
          nxt       = S_ISSUE_PUSH;
          do_push   = 1'b1;
          own_start = 1'b1;
          drv_cmd   = CMD_PUSH;
          drv_data  = {price_q, rem_q};
        end else begin
          nxt       = S_FINISH;
          do_reject = 1'b1;
        end
      end
      S_ISSUE_POP, S_ISSUE_UPD, S_ISSUE_PUSH: nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (bid_complete || ask_complete) nxt = S_SETTLE;
      S_SETTLE:    nxt = rested_q ? S_FINISH : S_EVAL;
      S_FINISH:    nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  assign bid_start = (opp_start && side_q == SIDE_SELL) || (own_start && side_q == SIDE_BUY);
  assign ask_start = (opp_start && side_q == SIDE_BUY)  || (own_start && side_q == SIDE_SELL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ready_q       <= 1'b0;
      side_q        <= 1'b0;
      price_q       <= '0;
      rem_q         <= '0;
      fills_q       <= '0;
      reject_q      <= 1'b0;
      rested_q      <= 1'b0;
      trade_valid_q <= 1'b0;
      trade_side_q  <= 1'b0;
      trade_price_q <= '0;
      trade_qty_q   <= '0;
    end else begin
      state         <= nxt;
      ready_q       <= (nxt == S_IDLE) && !bid_busy && !ask_busy && bid_idle && ask_idle;
      trade_valid_q <= 1'b0;
      if (accept) begin
        side_q   <= order_side;
        price_q  <= in_ord.price;
        rem_q    <= in_ord.qty;
        fills_q  <= '0;
        reject_q <= 1'b0;
        rested_q <= 1'b0;
      end
      if (do_fill) begin
        rem_q         <= rem_q - fill_qty;
        fills_q       <= fills_q + FILL_W'(1);
        trade_valid_q <= 1'b1;
        trade_side_q  <= side_q;
        trade_price_q <= opp_ord.price;
        trade_qty_q   <= fill_qty;
      end
      if (do_push) begin
        rem_q    <= '0;
        rested_q <= 1'b1;
      end
      if (do_reject) reject_q <= 1'b1;
    end
  end

  heap_port_driver u_bid_drv (
    .clk(clk), .rst(rst), .start(bid_start), .cmd_in(drv_cmd), .data_in(drv_data),
    .heap_done(bid_done), .cmd(bid_cmd), .data(bid_data), .complete(bid_complete),
    .idle(bid_idle)
  );

  heap_port_driver u_ask_drv (
    .clk(clk), .rst(rst), .start(ask_start), .cmd_in(drv_cmd), .data_in(drv_data),
    .heap_done(ask_done), .cmd(ask_cmd), .data(ask_data), .complete(ask_complete),
    .idle(ask_idle)
  );

  assign order_ready = ready_q;
  assign order_done  = (state == S_FINISH);
  assign reject      = order_done && reject_q;
  assign trade_valid = trade_valid_q;
  assign trade_side  = trade_side_q;
  assign trade_price = trade_price_q;
  assign trade_qty   = trade_qty_q;

endmodule

// File: tb/tb_order_match_engine.sv
// Directed bench: behavioural sorted-array heaps (bid=max, ask=min) with
// post-reset clear and command latency, plus an expected-trade scoreboard.
module tb_order_match_engine;
  import order_match_engine_pkg::*;

  localparam int LAT = 3;
  localparam int CLR = 40;

  typedef struct packed {
    logic        side;
    logic [15:0] price;
    logic [15:0] qty;
  } trade_t;

  logic        clk, rst;
  logic        order_valid, order_ready, order_side;
  logic [31:0] order_data;
  logic        order_done, reject, trade_valid, trade_side;
  logic [15:0] trade_price, trade_qty;
  logic [1:0]  bid_cmd, ask_cmd;
  logic [31:0] bid_data, ask_data, bid_root, ask_root;
  logic        bid_empty, bid_full, bid_busy, bid_done;
  logic        ask_empty, ask_full, ask_busy, ask_done;

  order_match_engine dut (
    .clk(clk), .rst(rst), .order_valid(order_valid), .order_ready(order_ready),
    .order_side(order_side), .order_data(order_data), .order_done(order_done),
    .reject(reject), .trade_valid(trade_valid), .trade_side(trade_side),
    .trade_price(trade_price), .trade_qty(trade_qty),
    .bid_cmd(bid_cmd), .bid_data(bid_data), .bid_root(bid_root), .bid_empty(bid_empty),
    .bid_full(bid_full), .bid_busy(bid_busy), .bid_done(bid_done),
    .ask_cmd(ask_cmd), .ask_data(ask_data), .ask_root(ask_root), .ask_empty(ask_empty),
    .ask_full(ask_full), .ask_busy(ask_busy), .ask_done(ask_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- heap models: index 0 = bid (cap 4), 1 = ask (cap 8)
  logic [31:0] mem [2][8];
  int          cnt [2];
  int          tmr [2];
  logic [1:0]  pcmd [2];
  logic [31:0] pdat [2];
  logic        hbusy [2];
  logic        hdone [2];

  function automatic int cap_of(input int h);
    return (h == 0) ? 4 : 8;
  endfunction

  function automatic logic better(input int h, input logic [31:0] a, input logic [31:0] b);
    return (h == 0) ? (a[31:16] > b[31:16]) : (a[31:16] < b[31:16]);
  endfunction

  task automatic apply(input int h, input logic [1:0] c, input logic [31:0] d);
    int pos;
    case (c)
      CMD_PUSH: if (cnt[h] < cap_of(h)) begin
        pos = cnt[h];
        for (int i = cnt[h] - 1; i >= 0; i--) if (better(h, d, mem[h][i])) pos = i;
        for (int i = cnt[h]; i > pos; i--) mem[h][i] = mem[h][i-1];
        mem[h][pos] = d;
        cnt[h]++;
      end
      CMD_POP: if (cnt[h] > 0) begin
        for (int i = 0; i < cnt[h] - 1; i++) mem[h][i] = mem[h][i+1];
        cnt[h]--;
      end
      CMD_UPDATE: mem[h][0] = d;
      default: ;
    endcase
  endtask

  initial begin
    logic [1:0]  cc [2];
    logic [31:0] cd [2];
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 8; i++) mem[h][i] = '0;
      cnt[h] = 0; tmr[h] = 0; pcmd[h] = CMD_NOP; pdat[h] = '0;
      hbusy[h] = 1'b1; hdone[h] = 1'b0;
    end
    repeat (CLR) @(posedge clk);
    #1;
    hbusy[0] = 1'b0;
    hbusy[1] = 1'b0;
    forever begin
      @(posedge clk);
      cc[0] = bid_cmd; cd[0] = bid_data;
      cc[1] = ask_cmd; cd[1] = ask_data;
      #1;
      for (int h = 0; h < 2; h++) begin
        hdone[h] = 1'b0;
        if (tmr[h] > 0) begin
          tmr[h]--;
          if (tmr[h] == 0) begin
            apply(h, pcmd[h], pdat[h]);
            hdone[h] = 1'b1;
          end
        end
        if (cc[h] != CMD_NOP) begin
          pcmd[h] = cc[h];
          pdat[h] = cd[h];
          tmr[h]  = LAT;
        end
        hbusy[h] = (tmr[h] > 0);
      end
    end
  end

  assign bid_root  = mem[0][0];
  assign ask_root  = mem[1][0];
  assign bid_empty = (cnt[0] == 0);
  assign ask_empty = (cnt[1] == 0);
  assign bid_full  = (cnt[0] == cap_of(0));
  assign ask_full  = (cnt[1] == cap_of(1));
  assign bid_busy  = hbusy[0];
  assign ask_busy  = hbusy[1];
  assign bid_done  = hdone[0];
  assign ask_done  = hdone[1];

  // ---------------- scoreboard and checking
  int         checks = 0;
  int         errors = 0;
  trade_t     exp_q[$];
  int         n_bid, n_ask, lat;
  logic [1:0] last_bid, last_ask;
  logic       saw_done, saw_reject;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_trade(input logic s, input logic [15:0] p, input logic [15:0] q);
    exp_q.push_back('{side: s, price: p, qty: q});
  endfunction

  task automatic mon_cycle();
    trade_t t;
    @(negedge clk);
    if (trade_valid) begin
      if (exp_q.size() == 0) check("unexpected_trade", 32'd1, 32'd0);
      else begin
        t = exp_q.pop_front();
        check("trade_side", {31'd0, trade_side}, {31'd0, t.side});
        check("trade_price", {16'd0, trade_price}, {16'd0, t.price});
        check("trade_qty", {16'd0, trade_qty}, {16'd0, t.qty});
      end
    end
    if (bid_cmd != CMD_NOP || ask_cmd != CMD_NOP) begin
      check("one_heap_per_cycle", {31'd0, (bid_cmd != CMD_NOP) && (ask_cmd != CMD_NOP)}, 32'd0);
      check("cmd_to_idle_heap", {31'd0, (bid_cmd != CMD_NOP) ? bid_busy : ask_busy}, 32'd0);
      if (bid_cmd != CMD_NOP) begin n_bid++; last_bid = bid_cmd; end
      if (ask_cmd != CMD_NOP) begin n_ask++; last_ask = ask_cmd; end
    end
    if (order_done) begin
      saw_done   = 1'b1;
      saw_reject = reject;
    end
  endtask

  task automatic begin_order(input logic s, input logic [15:0] p, input logic [15:0] q);
    int g = 0;
    @(negedge clk);
    while (!order_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("order_ready", {31'd0, order_ready}, 32'd1);
    n_bid = 0; n_ask = 0; last_bid = CMD_NOP; last_ask = CMD_NOP;
    saw_done = 1'b0; saw_reject = 1'b0; lat = 0;
    order_valid = 1'b1;
    order_side  = s;
    order_data  = {p, q};
    @(posedge clk);
    #1 order_valid = 1'b0;
  endtask

  task automatic run_order(input logic s, input logic [15:0] p, input logic [15:0] q);
    begin_order(s, p, q);
    while (!saw_done && lat < 400) begin
      mon_cycle();
      lat++;
    end
    check("order_done_seen", {31'd0, saw_done}, 32'd1);
    check("trades_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int g;
    rst = 1'b1; order_valid = 1'b0; order_side = 1'b0; order_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, order_ready}, 32'd0);
    check("rst_done", {31'd0, order_done}, 32'd0);
    check("rst_trade", {31'd0, trade_valid}, 32'd0);
    check("rst_cmds", {28'd0, bid_cmd, ask_cmd}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("ready_while_heaps_clear", {31'd0, order_ready}, 32'd0);

    // 1: empty book, buy rests on bid heap
    run_order(SIDE_BUY, 16'd100, 16'd10);
    check("t1_reject", {31'd0, saw_reject}, 32'd0);
    check("t1_bid_cmds", n_bid, 32'd1);
    check("t1_bid_push", {30'd0, last_bid}, {30'd0, CMD_PUSH});
    check("t1_ask_cmds", n_ask, 32'd0);
    check("t1_bid_root", bid_root, {16'd100, 16'd10});

    // 2: exact-price full fill pops the ask
    run_order(SIDE_SELL, 16'd101, 16'd5);
    expect_trade(SIDE_BUY, 16'd101, 16'd5);
    run_order(SIDE_BUY, 16'd101, 16'd5);
    check("t2_ask_pop", {30'd0, last_ask}, {30'd0, CMD_POP});
    check("t2_bid_cmds", n_bid, 32'd0);
    check("t2_ask_empty", {31'd0, ask_empty}, 32'd1);
    check("t2_bid_root", bid_root, {16'd100, 16'd10});

    // 3: partial fill of resting ask
    run_order(SIDE_SELL, 16'd101, 16'd8);
    expect_trade(SIDE_BUY, 16'd101, 16'd3);
    run_order(SIDE_BUY, 16'd102, 16'd3);
    check("t3_ask_update", {30'd0, last_ask}, {30'd0, CMD_UPDATE});
    check("t3_ask_root", ask_root, {16'd101, 16'd5});

    // clear the book
    expect_trade(SIDE_SELL, 16'd100, 16'd10);
    run_order(SIDE_SELL, 16'd100, 16'd10);
    expect_trade(SIDE_BUY, 16'd101, 16'd5);
    run_order(SIDE_BUY, 16'd101, 16'd5);
    check("clr_bid_empty", {31'd0, bid_empty}, 32'd1);
    check("clr_ask_empty", {31'd0, ask_empty}, 32'd1);

    // 4: sweep two levels, remainder rests
    run_order(SIDE_SELL, 16'd100, 16'd2);
    run_order(SIDE_SELL, 16'd101, 16'd2);
    run_order(SIDE_SELL, 16'd103, 16'd9);
    expect_trade(SIDE_BUY, 16'd100, 16'd2);
    expect_trade(SIDE_BUY, 16'd101, 16'd2);
    run_order(SIDE_BUY, 16'd101, 16'd10);
    check("t4_ask_cmds", n_ask, 32'd2);
    check("t4_bid_cmds", n_bid, 32'd1);
    check("t4_ask_root", ask_root, {16'd103, 16'd9});
    check("t4_bid_root", bid_root, {16'd101, 16'd6});

    // 5: own heap full -> reject
    expect_trade(SIDE_BUY, 16'd103, 16'd9);
    run_order(SIDE_BUY, 16'd103, 16'd9);
    run_order(SIDE_BUY, 16'd60, 16'd1);
    run_order(SIDE_BUY, 16'd61, 16'd1);
    run_order(SIDE_BUY, 16'd62, 16'd1);
    check("t5_bid_full", {31'd0, bid_full}, 32'd1);
    run_order(SIDE_BUY, 16'd50, 16'd1);
    check("t5_reject", {31'd0, saw_reject}, 32'd1);
    check("t5_no_cmds", n_bid + n_ask, 32'd0);
    check("t5_bid_count", cnt[0], 32'd4);
    check("t5_bid_root", bid_root, {16'd101, 16'd6});

    // 6: reset while waiting on the heap
    expect_trade(SIDE_SELL, 16'd101, 16'd2);
    begin_order(SIDE_SELL, 16'd101, 16'd2);
    g = 0;
    while (n_bid == 0 && g < 50) begin
      mon_cycle();
      g++;
    end
    check("t6_bid_update", {30'd0, last_bid}, {30'd0, CMD_UPDATE});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_cmds", {28'd0, bid_cmd, ask_cmd}, 32'd0);
    check("t6_rst_done", {31'd0, order_done}, 32'd0);
    check("t6_rst_ready", {31'd0, order_ready}, 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) mon_cycle();
    check("t6_no_order_done", {31'd0, saw_done}, 32'd0);
    check("t6_bid_root", bid_root, {16'd101, 16'd4});

    // zero quantity: done straight from EVAL, no commands
    run_order(SIDE_BUY, 16'd10, 16'd0);
    check("qty0_latency", lat, 32'd2);
    check("qty0_cmds", n_bid + n_ask, 32'd0);
    check("qty0_reject", {31'd0, saw_reject}, 32'd0);

    // new sell rests on the ask side after the reset
    run_order(SIDE_SELL, 16'd200, 16'd1);
    check("t6_ask_cmds", n_ask, 32'd1);
    check("t6_ask_root", ask_root, {16'd200, 16'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
